// File: rtl/bram_dp_pkg.sv
// Shared types and helpers for the banked true-dual-port block RAM.
package bram_dp_pkg;

   localparam int MAX_READ_LATENCY = 4;

   typedef struct packed {
      logic valid;
      logic oob;
   } rd_pipe_t;

   function automatic int bank_width(input int width, input int banks);
      return width / banks;
   endfunction

endpackage

// File: rtl/bram_dp_bank.sv
// One column bank: BW x DEPTH read-first true-dual-port array with registered reads.
// Port B is applied after port A, so B wins when both write the same lane.
module bram_dp_bank
   import bram_dp_pkg::*;
#(
   parameter int BW         = 64,
   parameter int DEPTH      = 20480,
   parameter int ADDR_WIDTH = 15,
   parameter int LANES      = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rda,
   input  logic                  clra,
   input  logic [LANES-1:0]      wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [BW-1:0]         dia,
   output logic [BW-1:0]         qa,
   input  logic                  rdb,
   input  logic                  clrb,
   input  logic [LANES-1:0]      web,
   input  logic [ADDR_WIDTH-1:0] addrb,
   input  logic [BW-1:0]         dib,
   output logic [BW-1:0]         qb
);

   localparam int LW = BW / LANES;

   logic [BW-1:0] mem [DEPTH];
   logic [BW-1:0] qa_reg, qb_reg;

   always_ff @(posedge clock) begin
      for (int l = 0; l < LANES; l++) begin
         if (wea[l]) mem[addra][l*LW +: LW] <= dia[l*LW +: LW];
         if (web[l]) mem[addrb][l*LW +: LW] <= dib[l*LW +: LW];
      end
   end

   // Out-of-range reads load zero instead of touching the array.
   always_ff @(posedge clock) begin
      if (reset) begin
         qa_reg <= '0;
         qb_reg <= '0;
      end else begin
         if (rda) qa_reg <= clra ? '0 : mem[addra];
         if (rdb) qb_reg <= clrb ? '0 : mem[addrb];
      end
   end

   assign qa = qa_reg;
   assign qb = qb_reg;

endmodule

// File: rtl/xilinx_block_ram_dp_banked.sv
// Banked single-clock true-dual-port block RAM with read pipeline, collision and oob flags.
// Optional byte write enables (ports bwea/bweb) when BRAM_DP_BYTE_WRITE_EN is defined.
module xilinx_block_ram_dp_banked
   import bram_dp_pkg::*;
#(
   parameter int WIDTH        = 512,
   parameter int DEPTH        = 20480,
   parameter int BANKS        = 8,
   parameter int READ_LATENCY = 2,
   parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ena,
   input  logic                  enb,
   input  logic                  wea,
   input  logic                  web,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [ADDR_WIDTH-1:0] addrb,
   input  logic [WIDTH-1:0]      dia,
   input  logic [WIDTH-1:0]      dib,
`ifdef BRAM_DP_BYTE_WRITE_EN
   input  logic [WIDTH/8-1:0]    bwea,
   input  logic [WIDTH/8-1:0]    bweb,
`endif
   output logic [WIDTH-1:0]      doa,
   output logic [WIDTH-1:0]      dob,
   output logic                  rvalida,
   output logic                  rvalidb,
   output logic                  collision,
   output logic                  oob
);

   localparam int BW = bank_width(WIDTH, BANKS);
`ifdef BRAM_DP_BYTE_WRITE_EN
   localparam int LPB = BW / 8;
`else
   localparam int LPB = 1;
`endif
   localparam int NL = BANKS * LPB;

   if (WIDTH % BANKS != 0) begin : g_bad_banks
      $error("WIDTH must be a multiple of BANKS");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..MAX_READ_LATENCY");
   end
`ifdef BRAM_DP_BYTE_WRITE_EN
   if (BW % 8 != 0) begin : g_bad_bytes
      $error("bank width must be a whole number of bytes");
   end
`endif

   logic [1:0]                 en_p, we_p, oob_p, rd_p, rvalid_p;
   logic [1:0][ADDR_WIDTH-1:0] addr_p;
   logic [1:0][WIDTH-1:0]      din_p, q_p, dout_p;
   logic [1:0][NL-1:0]         mask_p, lane_p, lane_eff;
   logic                       same_addr, collision_hit;
   logic                       collision_reg, oob_reg;

   assign en_p   = {enb, ena};
   assign we_p   = {web, wea};
   assign addr_p = {addrb, addra};
   assign din_p  = {dib, dia};
`ifdef BRAM_DP_BYTE_WRITE_EN
   assign mask_p = {bweb, bwea};
`else
   assign mask_p = '1;
`endif

   genvar gi;

   for (gi = 0; gi < 2; gi++) begin : g_req
      assign oob_p[gi]  = 32'(addr_p[gi]) >= 32'(DEPTH);
      assign rd_p[gi]   = en_p[gi] & ~we_p[gi] & ~reset;
      assign lane_p[gi] = {NL{en_p[gi] & we_p[gi] & ~oob_p[gi] & ~reset}} & mask_p[gi];
   end

   // Port A yields any lane port B also writes at the same address.
   assign same_addr     = (addra == addrb);
   assign collision_hit = same_addr & (|(lane_p[0] & lane_p[1]));
   assign lane_eff[0]   = lane_p[0] & ~(same_addr ? lane_p[1] : '0);
   assign lane_eff[1]   = lane_p[1];

   for (gi = 0; gi < BANKS; gi++) begin : g_bank
      bram_dp_bank #(
         .BW         (BW),
         .DEPTH      (DEPTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .LANES      (LPB)
      ) u_bank (
         .clock (clock),
         .reset (reset),
         .rda   (rd_p[0]),
         .clra  (oob_p[0]),
         .wea   (lane_eff[0][gi*LPB +: LPB]),
         .addra (addra),
         .dia   (dia[gi*BW +: BW]),
         .qa    (q_p[0][gi*BW +: BW]),
         .rdb   (rd_p[1]),
         .clrb  (oob_p[1]),
         .web   (lane_eff[1][gi*LPB +: LPB]),
         .addrb (addrb),
         .dib   (dib[gi*BW +: BW]),
         .qb    (q_p[1][gi*BW +: BW])
      );
   end

   for (gi = 0; gi < 2; gi++) begin : g_rd
      rd_pipe_t pipe_reg [1:READ_LATENCY];

      always_ff @(posedge clock) begin
         if (reset) begin
            for (int k = 1; k <= READ_LATENCY; k++) pipe_reg[k] <= '0;
         end else begin
            pipe_reg[1] <= '{valid: rd_p[gi], oob: oob_p[gi]};
            for (int k = 2; k <= READ_LATENCY; k++) pipe_reg[k] <= pipe_reg[k-1];
         end
      end

      assign rvalid_p[gi] = pipe_reg[READ_LATENCY].valid;

      if (READ_LATENCY == 1) begin : g_direct
         assign dout_p[gi] = q_p[gi];
      end else begin : g_stages
         logic [WIDTH-1:0] stage_reg [2:READ_LATENCY];

         // Stages advance only with a valid read, so the last one holds between reads.
         always_ff @(posedge clock) begin
            if (reset) begin
               for (int k = 2; k <= READ_LATENCY; k++) stage_reg[k] <= '0;
            end else begin
               if (pipe_reg[1].valid) stage_reg[2] <= pipe_reg[1].oob ? '0 : q_p[gi];
               for (int k = 3; k <= READ_LATENCY; k++) begin
                  if (pipe_reg[k-1].valid)
                     stage_reg[k] <= pipe_reg[k-1].oob ? '0 : stage_reg[k-1];
               end
            end
         end

         assign dout_p[gi] = stage_reg[READ_LATENCY];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         collision_reg <= 1'b0;
         oob_reg       <= 1'b0;
      end else begin
         collision_reg <= collision_reg | collision_hit;
         oob_reg       <= oob_reg | (ena & oob_p[0]) | (enb & oob_p[1]);
      end
   end

   assign doa       = dout_p[0];
   assign dob       = dout_p[1];
   assign rvalida   = rvalid_p[0];
   assign rvalidb   = rvalid_p[1];
   assign collision = collision_reg;
   assign oob       = oob_reg;

endmodule

// File: tb/tb_xilinx_block_ram_dp_banked.sv
// Directed bench for xilinx_block_ram_dp_banked with a word-level memory model and per-cycle compare.
module tb_xilinx_block_ram_dp_banked;

   localparam int WIDTH = 512;
   localparam int DEPTH = 20480;
   localparam int BANKS = 8;
   localparam int LAT   = 2;
   localparam int AW    = 15;
   localparam int NB    = WIDTH / 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             ena, enb, wea, web;
   logic [AW-1:0]    addra, addrb;
   logic [WIDTH-1:0] dia, dib;
   logic [WIDTH-1:0] doa, dob;
   logic             rvalida, rvalidb, collision, oob;
   logic [NB-1:0]    bwea_m, bweb_m;
`ifdef BRAM_DP_BYTE_WRITE_EN
   logic [NB-1:0]    bwea, bweb;
   assign bwea_m = bwea;
   assign bweb_m = bweb;
`else
   assign bwea_m = '1;
   assign bweb_m = '1;
`endif

   xilinx_block_ram_dp_banked #(
      .WIDTH        (WIDTH),
      .DEPTH        (DEPTH),
      .BANKS        (BANKS),
      .READ_LATENCY (LAT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ena       (ena),
      .enb       (enb),
      .wea       (wea),
      .web       (web),
      .addra     (addra),
      .addrb     (addrb),
      .dia       (dia),
      .dib       (dib),
`ifdef BRAM_DP_BYTE_WRITE_EN
      .bwea      (bwea),
      .bweb      (bweb),
`endif
      .doa       (doa),
      .dob       (dob),
      .rvalida   (rvalida),
      .rvalidb   (rvalidb),
      .collision (collision),
      .oob       (oob)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Model: word memory, a queue of reads due per port, and the expected output state.
   typedef struct {
      int               due;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic [WIDTH-1:0] mdl [int];
   exp_t             qa[$], qb[$];
   int               pcount = 0;
   bit               live = 0;
   logic             exp_va, exp_vb, exp_col, exp_oob;
   logic [WIDTH-1:0] exp_doa, exp_dob, wa, wb, rda_m, rdb_m;
   int               ai, bi;
   logic [NB-1:0]    ma, mb;

   function automatic logic [WIDTH-1:0] mget(input int a);
      return mdl.exists(a) ? mdl[a] : '0;
   endfunction

   always @(posedge clock) begin
      pcount++;
      if (reset) begin
         live = 1;
         qa.delete();
         qb.delete();
         exp_va = 0; exp_vb = 0; exp_col = 0; exp_oob = 0;
         exp_doa = '0; exp_dob = '0;
      end else if (live) begin
         ai = int'(addra);
         bi = int'(addrb);
         rda_m = (ai < DEPTH) ? mget(ai) : '0;
         rdb_m = (bi < DEPTH) ? mget(bi) : '0;
         if (ena && !wea) qa.push_back('{pcount + LAT - 1, rda_m});
         if (enb && !web) qb.push_back('{pcount + LAT - 1, rdb_m});
         if ((ena && ai >= DEPTH) || (enb && bi >= DEPTH)) exp_oob = 1;
         ma = (ena && wea && ai < DEPTH) ? bwea_m : '0;
         mb = (enb && web && bi < DEPTH) ? bweb_m : '0;
         if (ai == bi && (ma & mb) != '0) exp_col = 1;
         if (ma != '0) begin
            wa = mget(ai);
            for (int i = 0; i < NB; i++) if (ma[i]) wa[i*8 +: 8] = dia[i*8 +: 8];
            mdl[ai] = wa;
         end
         if (mb != '0) begin
            wb = mget(bi);
            for (int i = 0; i < NB; i++) if (mb[i]) wb[i*8 +: 8] = dib[i*8 +: 8];
            mdl[bi] = wb;
         end
         exp_va = 0;
         exp_vb = 0;
         if (qa.size() > 0 && qa[0].due == pcount) begin
            exp_va = 1; exp_doa = qa[0].data; void'(qa.pop_front());
         end
         if (qb.size() > 0 && qb[0].due == pcount) begin
            exp_vb = 1; exp_dob = qb[0].data; void'(qb.pop_front());
         end
      end
   end

   always @(negedge clock) begin
      if (live) begin
         check("rvalida", rvalida, exp_va);
         check("rvalidb", rvalidb, exp_vb);
         check("doa", doa, exp_doa);
         check("dob", dob, exp_dob);
         check("collision", collision, exp_col);
         check("oob", oob, exp_oob);
      end
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle();
      ena = 0; enb = 0; wea = 0; web = 0;
      addra = '0; addrb = '0; dia = '0; dib = '0;
`ifdef BRAM_DP_BYTE_WRITE_EN
      bwea = '1; bweb = '1;
`endif
   endtask

   task automatic req_a(input logic we, input int addr, input logic [WIDTH-1:0] d);
      ena = 1; wea = we; addra = AW'(addr); dia = d;
      $display("txn A %s addr=%0d", we ? "wr" : "rd", addr);
   endtask

   task automatic req_b(input logic we, input int addr, input logic [WIDTH-1:0] d);
      enb = 1; web = we; addrb = AW'(addr); dib = d;
      $display("txn B %s addr=%0d", we ? "wr" : "rd", addr);
   endtask

   logic [WIDTH-1:0] pa, px, py, pp, pq, pr, pz, merged;

   initial begin
      pa = {64{8'hA5}}; px = {64{8'h3C}}; py = {64{8'hC3}};
      pp = {32{16'h1234}}; pq = {32{16'hBEEF}}; pr = {16{32'h0BADF00D}}; pz = {64{8'h77}};
      reset = 1;
      idle();
      @(negedge clock);
      tick();
      check("reset_doa", doa, '0);
      check("reset_rvalidb", rvalidb, 1'b0);
      check("reset_collision", collision, 1'b0);
      check("reset_oob", oob, 1'b0);
      reset = 0;

      // Write then cross-port read: data two cycles after the request, for one cycle.
      req_a(1, 5, pa); tick(); idle();
      req_b(0, 5, '0); tick(); idle();
      check("t1_rvalidb_early", rvalidb, 1'b0);
      tick();
      check("t1_rvalidb", rvalidb, 1'b1);
      check("t1_dob", dob, pa);
      tick();
      check("t1_rvalidb_pulse", rvalidb, 1'b0);
      check("t1_dob_hold", dob, pa);

      // Same-address double write: B wins, collision sticky.
      req_a(1, 9, px); req_b(1, 9, py); tick(); idle();
      check("t2_collision", collision, 1'b1);
      req_a(0, 9, '0); req_b(0, 9, '0); tick(); idle(); tick();
      check("t2_doa", doa, py);
      check("t2_dob", dob, py);

      // Read-first on cross-port read/write.
      req_a(1, 3, pp); tick(); idle();
      req_a(1, 3, pq); req_b(0, 3, '0); tick(); idle(); tick();
      check("t3_dob_old", dob, pp);
      check("t3_doa_unchanged", doa, py);
      req_b(0, 3, '0); tick(); idle(); tick();
      check("t3_dob_new", dob, pq);

      // Out of range: read returns zero, write suppressed without aliasing.
      req_a(1, 4097, pr); tick(); idle();
      req_b(0, DEPTH, '0); tick(); idle();
      check("t4_oob", oob, 1'b1);
      tick();
      check("t4_rvalidb", rvalidb, 1'b1);
      check("t4_dob_zero", dob, '0);
      req_a(1, DEPTH + 1, pz); tick(); idle();
      req_b(0, 4097, '0); tick(); idle(); tick();
      check("t4_no_alias", dob, pr);

      // Back-to-back reads on both ports, mixed with a write.
      req_a(0, 5, '0); req_b(0, 3, '0); tick();
      idle(); req_a(0, 9, '0); req_b(1, 12, pz); tick();
      idle(); req_a(0, 3, '0); req_b(0, 12, '0); tick();
      idle(); tick(); tick(); tick();
      check("t5_dob_b2b", dob, pz);

      // Reset in the middle of back-to-back reads flushes them all.
      req_a(0, 5, '0); tick();
      reset = 1; req_a(0, 9, '0); tick();
      req_a(0, 3, '0); tick();
      reset = 0; idle();
      for (int i = 0; i < 4; i++) tick();
      check("t5_rvalida", rvalida, 1'b0);
      check("t5_doa", doa, '0);
      check("t5_collision_clr", collision, 1'b0);
      check("t5_oob_clr", oob, 1'b0);

`ifdef BRAM_DP_BYTE_WRITE_EN
      // Disjoint byte masks merge without collision; overlapping masks collide.
      req_a(1, 11, {64{8'hFF}}); tick(); idle();
      bwea = 64'h0F; bweb = 64'hF0;
      req_a(1, 11, {64{8'h11}}); req_b(1, 11, {64{8'h22}}); tick(); idle();
      check("t6_no_collision", collision, 1'b0);
      req_a(0, 11, '0); tick(); idle(); tick();
      merged = {{56{8'hFF}}, {4{8'h22}}, {4{8'h11}}};
      check("t6_merged", doa, merged);
      bwea = 64'h1; bweb = 64'h3;
      req_a(1, 11, {64{8'h44}}); req_b(1, 11, {64{8'h55}}); tick(); idle();
      check("t6_collision", collision, 1'b1);
      req_b(0, 11, '0); tick(); idle(); tick();
      merged = {{56{8'hFF}}, {4{8'h22}}, {2{8'h11}}, {2{8'h55}}};
      check("t6_overlap", dob, merged);
`endif

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
